// File: rtl/rib_dmem_resp.sv
// RIB data-memory responder: one request at a time, registered read word,
// Moore acknowledge after WAIT_CYCLES wait states, store commits merged word on ACK exit.
module rib_dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] raddr_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned IdxW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SpanBytes = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, READ, WAIT, ACK} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rdOff, wrOff;
  logic              rdInRange, wrInRange;
  logic              we_q, err_q, rdOk_q;
  logic [IdxW-1:0]   rdIdx_q, wrIdx_q;
  logic [3:0]        waitCnt_q;
  logic [31:0]       rdata_q;
  logic              memWe;

  // Offsets wrap modulo 2^32, so addresses below the base land far above the span.
  assign rdOff     = raddr_i - ADDR_BASE;
  assign wrOff     = waddr_i - ADDR_BASE;
  assign rdInRange = rdOff < SpanBytes;
  assign wrInRange = wrOff < SpanBytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = READ;
      READ:    state_d = (WaitInit != 4'd0) ? WAIT : ACK;
      WAIT:    if (waitCnt_q == 4'd1) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rdOk_q    <= 1'b0;
      rdIdx_q   <= '0;
      wrIdx_q   <= '0;
      waitCnt_q <= 4'd0;
      rdata_q   <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (req_i) begin
          we_q    <= we_i;
          rdOk_q  <= rdInRange;
          err_q   <= !rdInRange || (we_i && !wrInRange);
          rdIdx_q <= rdOff[IdxW+1:2];
          wrIdx_q <= wrOff[IdxW+1:2];
        end
        READ: begin
          rdata_q   <= rdOk_q ? mem[rdIdx_q] : 32'd0;
          waitCnt_q <= WaitInit;
        end
        WAIT:    waitCnt_q <= waitCnt_q - 4'd1;
        default: ;
      endcase
    end
  end

  // Gating with rst keeps a reset that coincides with the ACK exit edge from committing.
  assign memWe = (state_q == ACK) && we_q && !err_q && !rst;

  always_ff @(posedge clk) begin
    if (memWe) mem[wrIdx_q] <= wdata_i;
  end

  always_comb begin
    ack_o  = 1'b0;
    err_o  = 1'b0;
    busy_o = (state_q != IDLE);
    if (state_q == ACK) begin
      ack_o = 1'b1;
      err_o = err_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_rib_dmem_resp.sv
// Randomized self-checking bench for rib_dmem_resp: one instance with one wait
// state, one with none, each checked against a behavioural word-array model.
module tb_rib_dmem_resp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
  localparam logic [31:0] ALL   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] raddr [2];
  logic [31:0] waddr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] modelMem   [2][DEPTH];
  bit          modelKnown [2][DEPTH];

  always #5 clk = ~clk;

  rib_dmem_resp #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE), .WAIT_CYCLES(1)) dutW1 (
    .clk(clk), .rst(rst[0]), .req_i(req[0]), .we_i(we[0]), .raddr_i(raddr[0]),
    .waddr_i(waddr[0]), .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
    .err_o(err[0]), .busy_o(busy[0]));

  rib_dmem_resp #(.DEPTH_WORDS(DEPTH), .ADDR_BASE(BASE), .WAIT_CYCLES(0)) dutW0 (
    .clk(clk), .rst(rst[1]), .req_i(req[1]), .we_i(we[1]), .raddr_i(raddr[1]),
    .waddr_i(waddr[1]), .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
    .err_o(err[1]), .busy_o(busy[1]));

  function automatic int waitOf(input int sel);
    return (sel == 0) ? 1 : 0;
  endfunction

  function automatic bit inRange(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < LIMIT;
  endfunction

  function automatic int wordOf(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return int'(off & 32'(DEPTH - 1));
  endfunction

  function automatic logic [31:0] pickAddr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'd4 - $urandom_range(0, 7);
      1:       return BASE + LIMIT + $urandom_range(0, 7);
      default: return BASE + $urandom_range(0, 4 * DEPTH - 1);
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; stores merge newBits under mask into the word seen at ACK.
  task automatic applyStimulus(input int sel, input bit isStore, input logic [31:0] ra,
                               input logic [31:0] wa, input logic [31:0] newBits,
                               input logic [31:0] mask);
    bit          rOk, wOk, expErr, known, sawAck;
    logic [31:0] expR;
    int          cyc;
    rOk    = inRange(ra);
    wOk    = inRange(wa);
    expErr = isStore ? !(rOk && wOk) : !rOk;
    expR   = rOk ? modelMem[sel][wordOf(ra)] : 32'h0;
    known  = !rOk || modelKnown[sel][wordOf(ra)];
    @(negedge clk);
    req[sel]   = 1'b1;
    we[sel]    = isStore;
    raddr[sel] = ra;
    waddr[sel] = wa;
    wdata[sel] = $urandom;
    cyc    = -1;
    sawAck = 1'b0;
    while (!sawAck && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 0) begin
        checkOutput("busy_after_accept", 32'(busy[sel]), 32'd1);
        raddr[sel] = $urandom;
        waddr[sel] = $urandom;
        we[sel]    = !isStore;
      end
      if (cyc == 1 && known) checkOutput("rdata_after_e1", rdata[sel], expR);
      if (ack[sel]) begin
        sawAck = 1'b1;
        checkOutput("err_at_ack", 32'(err[sel]), 32'(expErr));
        checkOutput("busy_at_ack", 32'(busy[sel]), 32'd1);
        if (known) checkOutput("rdata_at_ack", rdata[sel], expR);
        wdata[sel] = (rdata[sel] & ~mask) | (newBits & mask);
        req[sel]   = 1'b0;
      end
    end
    checkOutput("ack_latency", 32'(cyc), 32'(1 + waitOf(sel)));
    @(negedge clk);
    checkOutput("idle_after_ack", {30'd0, ack[sel], busy[sel]}, 32'd0);
    if (isStore && !expErr && (known || mask == ALL)) begin
      modelMem[sel][wordOf(wa)]   = (expR & ~mask) | (newBits & mask);
      modelKnown[sel][wordOf(wa)] = 1'b1;
    end
  endtask

  initial begin
    int ack1, ack2;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b0; req[s] = 1'b0; we[s] = 1'b0;
      raddr[s] = BASE; waddr[s] = BASE; wdata[s] = 32'd0;
      for (int w = 0; w < DEPTH; w++) modelKnown[s][w] = 1'b0;
    end

    // Asynchronous reset, asserted between clock edges.
    #3;
    rst[0] = 1'b1; rst[1] = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_rdata", rdata[s], 32'd0);
      checkOutput("reset_ack", 32'(ack[s]), 32'd0);
      checkOutput("reset_err", 32'(err[s]), 32'd0);
      checkOutput("reset_busy", 32'(busy[s]), 32'd0);
    end
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        applyStimulus(s, 1'b1, BASE + 32'(4 * w), BASE + 32'(4 * w), $urandom, ALL);

    applyStimulus(0, 1'b1, BASE + 32'd12, BASE + 32'd12, 32'hDEAD_BEEF, ALL);
    applyStimulus(0, 1'b0, BASE + 32'd12, BASE + 32'd12, 32'd0, 32'd0);
    checkOutput("load_deadbeef", rdata[0], 32'hDEAD_BEEF);

    applyStimulus(0, 1'b1, BASE, BASE, 32'h1122_3344, ALL);
    applyStimulus(0, 1'b1, BASE + 32'd1, BASE + 32'd1, 32'h0000_AA00, 32'h0000_FF00);
    applyStimulus(0, 1'b0, BASE, BASE, 32'd0, 32'd0);
    checkOutput("rmw_result", rdata[0], 32'h1122_AA44);

    applyStimulus(0, 1'b0, BASE + LIMIT, BASE + LIMIT, 32'd0, 32'd0);
    applyStimulus(0, 1'b1, BASE - 32'd4, BASE - 32'd4, $urandom, ALL);
    applyStimulus(0, 1'b1, BASE + 32'd28, BASE - 32'd4, $urandom, ALL);
    applyStimulus(0, 1'b1, BASE - 32'd4, BASE + 32'd32, $urandom, ALL);
    applyStimulus(0, 1'b0, BASE + 32'd28, BASE, 32'd0, 32'd0);
    applyStimulus(0, 1'b0, BASE + 32'd32, BASE, 32'd0, 32'd0);

    // Reset pulsed while the store waits.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; raddr[0] = BASE + 32'd36; waddr[0] = BASE + 32'd36;
    wdata[0] = ~modelMem[0][9];
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_in_wait", 32'(busy[0]), 32'd1);
    #1 rst[0] = 1'b1;
    #1;
    checkOutput("rst_wait_busy", 32'(busy[0]), 32'd0);
    checkOutput("rst_wait_ack", 32'(ack[0]), 32'd0);
    checkOutput("rst_wait_rdata", rdata[0], 32'd0);
    req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    applyStimulus(0, 1'b0, BASE + 32'd36, BASE, 32'd0, 32'd0);

    // Reset asserted inside the ACK cycle must suppress the write.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; raddr[1] = BASE + 32'd40; waddr[1] = BASE + 32'd40;
    wdata[1] = ~modelMem[1][10];
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_rst_ack", 32'(ack[1]), 32'd1);
    #1 rst[1] = 1'b1;
    #1;
    checkOutput("rst_ack_drop", 32'(ack[1]), 32'd0);
    req[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    applyStimulus(1, 1'b0, BASE + 32'd40, BASE, 32'd0, 32'd0);

    // Back-to-back loads with req held high; inputs scrambled mid-transaction.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; raddr[1] = BASE + 32'd20; waddr[1] = BASE;
    ack1 = -1; ack2 = -1;
    for (int c = 0; c < 20 && ack2 < 0; c++) begin
      @(negedge clk);
      if (c == 0) raddr[1] = BASE + 32'd24;
      if (c == 3) begin raddr[1] = BASE; we[1] = 1'b1; end
      if (ack[1]) begin
        if (ack1 < 0) begin
          ack1 = c;
          checkOutput("b2b_rdata_w5", rdata[1], modelMem[1][5]);
        end else begin
          ack2 = c;
          checkOutput("b2b_rdata_w6", rdata[1], modelMem[1][6]);
          req[1] = 1'b0; we[1] = 1'b0;
        end
      end
    end
    checkOutput("b2b_first_ack", 32'(ack1), 32'd1);
    checkOutput("b2b_ack_gap", 32'(ack2 - ack1), 32'd3);
    @(negedge clk);
    checkOutput("b2b_idle", {30'd0, ack[1], busy[1]}, 32'd0);
    applyStimulus(1, 1'b0, BASE, BASE, 32'd0, 32'd0);

    for (int n = 0; n < 80; n++) begin
      int          sel, lane;
      bit          st;
      logic [31:0] ra, wa, mk;
      sel  = $urandom_range(0, 1);
      st   = 1'($urandom_range(0, 1));
      ra   = pickAddr();
      wa   = ($urandom_range(0, 9) < 7) ? ra : pickAddr();
      lane = $urandom_range(0, 4);
      mk   = (lane == 4) ? ALL : (32'hFF << (8 * lane));
      applyStimulus(sel, st, ra, wa, $urandom, mk);
    end

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 8; w++)
        applyStimulus(s, 1'b0, BASE + 32'(4 * w), BASE, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
